// File: rtl/v74x_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : v74x_pkg
//  Purpose  : Shared constants and state encodings for the v74x encoder family.
//  Revision : 1.0
// ============================================================================
package v74x_pkg;

    localparam int c_default_n = 8;
    localparam int c_default_w = 3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

endpackage : v74x_pkg
`default_nettype wire

// File: rtl/prio_enc_comb.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc_comb
//  Purpose  : Combinational highest-set-bit finder with an any-bit-set flag.
//  Revision : 1.0
// ============================================================================
module prio_enc_comb
    import v74x_pkg::*;
#(
    parameter int N = c_default_n,
    parameter int W = c_default_w
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_req[i]) begin
                o_idx = W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule : prio_enc_comb
`default_nettype wire

// File: rtl/v74x148_sync_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : v74x148_sync_encoder
//  Purpose  : Clocked 8-line priority encoder with pending capture and a
//             VALID/ACK handshake on an active-low code.
//  Revision : 1.0
// ============================================================================
module v74x148_sync_encoder
    import v74x_pkg::*;
#(
    parameter int N = c_default_n,
    parameter int W = c_default_w
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         EI_L,
    input  logic [N-1:0] I_L,
    input  logic         ACK,
    output logic [W-1:0] A_L,
    output logic         GS_L,
    output logic         EO_L,
    output logic         VALID
);

    logic [N-1:0] r_pend;
    state_t       r_state;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_a_l;
    logic         r_valid;
    logic         r_gs_l;
    logic         r_eo_l;

    logic [N-1:0] w_set;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pend_next;
    state_t       w_state_next;
    logic [W-1:0] w_idx_next;
    logic [W-1:0] w_a_l_next;
    logic         w_valid_next;
    logic         w_eo_l_next;
    logic [W-1:0] w_top_idx;
    logic         w_top_any;

    prio_enc_comb #(
        .N (N),
        .W (W)
    ) u_prio (
        .i_req (r_pend),
        .o_idx (w_top_idx),
        .o_any (w_top_any)
    );

    // Pending update: an ACK clears the served bit, but a same-cycle request
    // on that line is OR'ed back in afterwards so the set always wins.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (!EI_L) begin
            w_set = ~I_L;
        end
        if ((r_state == S_HOLD) && ACK) begin
            w_clr[r_idx] = 1'b1;
        end
        w_pend_next = (r_pend & ~w_clr) | w_set;
        w_eo_l_next = ~(!EI_L && (r_pend == '0) && (&I_L));
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_a_l_next   = r_a_l;
        w_valid_next = r_valid;
        case (r_state)
            S_IDLE: begin
                if (w_top_any) begin
                    w_state_next = S_HOLD;
                    w_idx_next   = w_top_idx;
                    w_a_l_next   = ~w_top_idx;
                    w_valid_next = 1'b1;
                end
            end
            S_HOLD: begin
                // Held grant is never preempted; only ACK releases it.
                if (ACK) begin
                    w_state_next = S_IDLE;
                    w_a_l_next   = '1;
                    w_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_a_l_next   = '1;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pend  <= '0;
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a_l   <= '1;
            r_valid <= 1'b0;
            r_gs_l  <= 1'b1;
            r_eo_l  <= 1'b1;
        end else begin
            r_pend  <= w_pend_next;
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_a_l   <= w_a_l_next;
            r_valid <= w_valid_next;
            r_gs_l  <= ~w_valid_next;
            r_eo_l  <= w_eo_l_next;
        end
    end

    assign A_L   = r_a_l;
    assign GS_L  = r_gs_l;
    assign EO_L  = r_eo_l;
    assign VALID = r_valid;

endmodule : v74x148_sync_encoder
`default_nettype wire
